// File: rtl/line_tap_buffer.sv
// line_tap_buffer: TAPS cascaded line delays sharing one pointer; slice k = input delayed (k+1)*L beats.
// Optional build macro LINE_TAP_BUFFER_ZERO_FILL_EN forces a slice to zero until its tap_val bit is set.
module line_tap_buffer #(
  parameter int WIDTH = 8,
  parameter int D     = 640,
  parameter int B     = 10,
  parameter int TAPS  = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ena,
  input  logic                    flush,
  input  logic [B-1:0]            len_cfg,
  input  logic [WIDTH-1:0]        dat_in,
  output logic [TAPS*WIDTH-1:0]   tap_out,
  output logic [TAPS-1:0]         tap_val,
  output logic                    primed
);

  localparam int            AW     = (D > 1) ? $clog2(D) : 1;
  localparam int            CW     = $clog2(TAPS + 1);
  localparam logic [B-1:0]  D_B    = B'(D);
  localparam logic [CW-1:0] TAPS_C = CW'(TAPS);

  logic [B-1:0]                 w_len_eff;
  logic [B-1:0]                 r_len;
  logic [B-1:0]                 r_adr;
  logic [CW-1:0]                r_lines;
  logic                         w_beat;
  logic                         w_wrap;
  logic [AW-1:0]                w_madr;
  logic [TAPS-1:0]              r_val;
  logic [TAPS-1:0]              w_val_set;
  logic [TAPS-1:0][WIDTH-1:0]   w_rd;
  logic [TAPS-1:0][WIDTH-1:0]   w_wr;

  // Zero or oversize lengths fall back to the full line.
  assign w_len_eff = ((len_cfg == '0) || (len_cfg > D_B)) ? D_B : len_cfg;
  assign w_beat    = ena & ~flush;
  assign w_wrap    = (r_adr == (r_len - B'(1)));
  assign w_madr    = r_adr[AW-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_len <= w_len_eff;
    end else if (flush) begin
      r_len <= w_len_eff;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_adr   <= '0;
      r_lines <= '0;
    end else if (flush) begin
      r_adr   <= '0;
      r_lines <= '0;
    end else if (ena) begin
      r_adr <= w_wrap ? '0 : (r_adr + B'(1));
      if (w_wrap && (r_lines != TAPS_C)) begin
        r_lines <= r_lines + CW'(1);
      end
    end
  end

  // Slice k first holds sample 0 on the beat after k+1 completed lines.
  always_comb begin
    w_val_set = '0;
    for (int k = 0; k < TAPS; k++) begin
      w_val_set[k] = (r_lines > CW'(k));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_val <= '0;
    end else if (flush) begin
      r_val <= '0;
    end else if (ena) begin
      r_val <= r_val | w_val_set;
    end
  end

  for (genvar k = 0; k < TAPS; k++) begin : g_tap
    logic [WIDTH-1:0] r_mem [D];
    logic [WIDTH-1:0] r_tap;

    if (k == 0) begin : g_head
      assign w_wr[k] = dat_in;
    end else begin : g_chain
      assign w_wr[k] = w_rd[k-1];
    end

    assign w_rd[k] = r_mem[w_madr];

    always_ff @(posedge clk) begin
      if (w_beat) begin
        r_mem[w_madr] <= w_wr[k];
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_tap <= '0;
      end else if (flush) begin
        r_tap <= '0;
      end else if (ena) begin
        r_tap <= w_rd[k];
      end
    end

`ifdef LINE_TAP_BUFFER_ZERO_FILL_EN
    assign tap_out[k*WIDTH +: WIDTH] = r_val[k] ? r_tap : '0;
`else
    assign tap_out[k*WIDTH +: WIDTH] = r_tap;
`endif
  end

  assign tap_val = r_val;
  assign primed  = r_val[TAPS-1];

endmodule

// File: tb/tb_line_tap_buffer.sv
// Scoreboard bench for line_tap_buffer: stimulus pushes expected outputs, a monitor pops and compares.
module tb_line_tap_buffer;
  localparam int WIDTH = 8;
  localparam int D     = 640;
  localparam int B     = 10;
  localparam int TAPS  = 4;
  localparam int TW    = TAPS * WIDTH;
`ifdef LINE_TAP_BUFFER_ZERO_FILL_EN
  localparam bit ZF = 1'b1;
`else
  localparam bit ZF = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             ena;
  logic             flush;
  logic [B-1:0]     len_cfg;
  logic [WIDTH-1:0] dat_in;
  logic [TW-1:0]    tap_out;
  logic [TAPS-1:0]  tap_val;
  logic             primed;

  line_tap_buffer #(.WIDTH(WIDTH), .D(D), .B(B), .TAPS(TAPS)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .flush(flush), .len_cfg(len_cfg),
    .dat_in(dat_in), .tap_out(tap_out), .tap_val(tap_val), .primed(primed)
  );

  always #5 clk = ~clk;

  typedef struct {
    int              tag;
    logic [TAPS-1:0] val;
    logic [TW-1:0]   dat;
    logic [TW-1:0]   dmask;
  } exp_t;

  exp_t             sb[$];
  exp_t             last_e;
  exp_t             mon_e;
  logic [WIDTH-1:0] hist[$];
  int               model_len;
  int               nb;
  int               tag_cnt = 0;
  int               n_chk = 0;
  int               n_fail = 0;

  function automatic int eff_len(input int c);
    return ((c == 0) || (c > D)) ? D : c;
  endfunction

  function automatic void chk(input string nm, input int tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (step %0d): got %0h, expected %0h", nm, tag, act, exp);
    end
  endfunction

  task automatic model_restart(input int len);
    model_len    = eff_len(len);
    nb           = 0;
    hist.delete();
    last_e.val   = '0;
    last_e.dat   = '0;
    last_e.dmask = '1;
  endtask

  // Expected outputs after beat b: slice k = sample b-(k+1)*L once that sample exists.
  task automatic push_beat(input logic [WIDTH-1:0] d);
    exp_t e;
    int   b;
    int   off;
    hist.push_back(d);
    b       = nb;
    nb++;
    e.tag   = tag_cnt;
    e.val   = '0;
    e.dat   = '0;
    e.dmask = '0;
    for (int k = 0; k < TAPS; k++) begin
      off = (k + 1) * model_len;
      if (b >= off) begin
        e.val[k]                    = 1'b1;
        e.dat[k*WIDTH +: WIDTH]     = hist[b-off];
        e.dmask[k*WIDTH +: WIDTH]   = '1;
      end else if (ZF) begin
        e.dmask[k*WIDTH +: WIDTH]   = '1;
      end
    end
    last_e = e;
    sb.push_back(e);
  endtask

  task automatic drive(input logic e, input logic [WIDTH-1:0] d);
    @(negedge clk);
    ena    = e;
    flush  = 1'b0;
    dat_in = d;
    tag_cnt++;
    if (e) begin
      push_beat(d);
    end else begin
      last_e.tag = tag_cnt;
      sb.push_back(last_e);
    end
  endtask

  task automatic do_flush(input int len, input logic e, input logic [WIDTH-1:0] d);
    @(negedge clk);
    len_cfg = B'(len);
    flush   = 1'b1;
    ena     = e;
    dat_in  = d;
    tag_cnt++;
    model_restart(len);
    last_e.tag = tag_cnt;
    sb.push_back(last_e);
  endtask

  task automatic run_beats(input int n, input int first);
    for (int i = 0; i < n; i++) begin
      drive(1'b1, WIDTH'(first + i));
    end
  endtask

  // Directed check just after the edge that applies the last driven cycle.
  task automatic look(input string nm, input logic [TAPS-1:0] v, input logic [TW-1:0] dat, input logic [TW-1:0] m);
    @(posedge clk);
    #2;
    chk({nm, "_val"}, tag_cnt, 64'(tap_val), 64'(v));
    chk({nm, "_out"}, tag_cnt, 64'(tap_out & m), 64'(dat & m));
  endtask

  initial begin : monitor
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        chk("tap_val", mon_e.tag, 64'(tap_val), 64'(mon_e.val));
        chk("primed", mon_e.tag, 64'(primed), 64'(mon_e.val[TAPS-1]));
        chk("tap_out", mon_e.tag, 64'(tap_out & mon_e.dmask), 64'(mon_e.dat & mon_e.dmask));
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got timeout, expected test completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    rst_n   = 1'b0;
    ena     = 1'b0;
    flush   = 1'b0;
    len_cfg = B'(5);
    dat_in  = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_tap_val", 0, 64'(tap_val), 64'd0);
    chk("rst_primed", 0, 64'(primed), 64'd0);
    chk("rst_tap_out", 0, 64'(tap_out), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_restart(5);

    // L=5, continuous ena, ramp data
    run_beats(5, 0);
    look("l5_pre", 4'b0000, 32'h0, 32'h0);
    drive(1'b1, 8'd5);
    look("l5_tap0", 4'b0001, 32'h0000_0000, 32'h0000_00ff);
    run_beats(15, 6);
    look("l5_primed", 4'b1111, 32'h0005_0a0f, 32'hffff_ffff);
    run_beats(3, 21);

    // L=5, ena toggling: outputs hold on idle cycles
    do_flush(5, 1'b0, 8'h00);
    for (int i = 0; i < 21; i++) begin
      drive(1'b1, WIDTH'(i));
      drive(1'b0, 8'hee);
    end
    look("toggle_hold", 4'b1111, 32'h0005_0a0f, 32'hffff_ffff);

    // len_cfg=0 and len_cfg=D+3 both select L=D
    do_flush(0, 1'b0, 8'h00);
    run_beats(D, 0);
    look("len0_pre", 4'b0000, 32'h0, 32'h0);
    drive(1'b1, WIDTH'(D));
    look("len0_tap0", 4'b0001, 32'h0, 32'h0000_00ff);
    do_flush(D + 3, 1'b0, 8'h00);
    run_beats(D, 3);
    look("lenbig_pre", 4'b0000, 32'h0, 32'h0);
    drive(1'b1, WIDTH'(D + 3));
    look("lenbig_tap0", 4'b0001, 32'h0000_0003, 32'h0000_00ff);

    // Flush mid-stream with ena high; new length 3; later len_cfg change ignored
    do_flush(5, 1'b0, 8'h00);
    run_beats(13, 0);
    do_flush(3, 1'b1, 8'haa);
    look("flush_clr", 4'b0000, 32'h0, 32'hffff_ffff);
    len_cfg = B'(7);
    run_beats(3, 8'h40);
    look("f3_pre", 4'b0000, 32'h0, 32'h0);
    drive(1'b1, 8'h43);
    look("f3_tap0", 4'b0001, 32'h0000_0040, 32'h0000_00ff);
    run_beats(10, 8'h44);
    look("f3_primed", 4'b1111, 32'h4144_474a, 32'hffff_ffff);

    // Asynchronous reset mid-line, then refill with L=2 loaded during reset
    do_flush(4, 1'b0, 8'h00);
    run_beats(8, 0);
    @(posedge clk);
    #3;
    len_cfg = B'(2);
    ena     = 1'b0;
    rst_n   = 1'b0;
    #1;
    chk("arst_tap_val", tag_cnt, 64'(tap_val), 64'd0);
    chk("arst_primed", tag_cnt, 64'(primed), 64'd0);
    chk("arst_tap_out", tag_cnt, 64'(tap_out), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_restart(2);
    run_beats(8, 8'h60);
    look("rst_pre", 4'b0111, 32'h0, 32'h0);
    drive(1'b1, 8'h68);
    look("rst_primed", 4'b1111, 32'h6062_6466, 32'hffff_ffff);

    // L=1: each tap is a single register stage
    do_flush(1, 1'b0, 8'h00);
    run_beats(4, 8'h10);
    look("l1_pre", 4'b0111, 32'h0010_1112, 32'h00ff_ffff);
    drive(1'b1, 8'h14);
    look("l1_primed", 4'b1111, 32'h1011_1213, 32'hffff_ffff);
    run_beats(3, 8'h15);

    repeat (3) @(negedge clk);
    chk("sb_drain", tag_cnt, 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
